// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream round-robin arbiter.
package axis_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [1:0]  GRANT_NONE    = 2'd3;
    localparam int unsigned NUM_ARB_PORTS = 3;

    // Port index reached by stepping 'step' places after 'base', modulo 3.
    function automatic logic [1:0] port_after(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep AXI-Stream register slice: breaks the combinational path from input to output.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  load;

    // Accept a new beat when empty or when the held beat leaves this cycle.
    assign s_axis_tready = !valid_q || m_axis_tready;
    assign load          = s_axis_tvalid && s_axis_tready;

    // Slice storage: load on input handshake, drain on output handshake, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            data_q  <= s_axis_tdata;
            keep_q  <= s_axis_tkeep;
            valid_q <= 1'b1;
            last_q  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Three-to-one packet-granular round-robin AXI-Stream arbiter with a registered output.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            grant,
    output logic                  busy
);

    arb_state_e state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_q, last_d;
    logic [1:0] pick;
    logic [NUM_ARB_PORTS-1:0] req;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  slice_valid;
    logic                  slice_ready;
    logic                  locked;
    logic                  xfer;

    assign req    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign locked = (state_q == ARB_LOCKED);

    // Round-robin pick: the nearest requester after the last owner; the last owner comes last.
    always_comb begin
        pick = last_q;
        for (int k = 3; k >= 1; k--) begin
            if (req[port_after(last_q, 2'(k))]) begin
                pick = port_after(last_q, 2'(k));
            end
        end
    end

    // Input select mux driven by the current owner.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        unique case (grant_q)
            2'd0: begin
                sel_data  = s_axis_tdata_0;
                sel_keep  = s_axis_tkeep_0;
                sel_valid = s_axis_tvalid_0;
                sel_last  = s_axis_tlast_0;
            end
            2'd1: begin
                sel_data  = s_axis_tdata_1;
                sel_keep  = s_axis_tkeep_1;
                sel_valid = s_axis_tvalid_1;
                sel_last  = s_axis_tlast_1;
            end
            2'd2: begin
                sel_data  = s_axis_tdata_2;
                sel_keep  = s_axis_tkeep_2;
                sel_valid = s_axis_tvalid_2;
                sel_last  = s_axis_tlast_2;
            end
            default: ;
        endcase
    end

    assign slice_valid = locked && sel_valid;
    assign xfer        = slice_valid && slice_ready;

    // Only the owner sees ready, and only while the slice can take a beat.
    assign s_axis_tready_0 = locked && (grant_q == 2'd0) && slice_ready;
    assign s_axis_tready_1 = locked && (grant_q == 2'd1) && slice_ready;
    assign s_axis_tready_2 = locked && (grant_q == 2'd2) && slice_ready;

    // Next-state: arbitrate in IDLE, release the lock when the tlast beat transfers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (xfer && sel_last) begin
                    last_d  = grant_q;
                    grant_d = GRANT_NONE;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                grant_d = GRANT_NONE;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State register; last owner resets to 2 so port 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= GRANT_NONE;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    axis_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_slice (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (sel_data),
        .s_axis_tkeep  (sel_keep),
        .s_axis_tvalid (slice_valid),
        .s_axis_tready (slice_ready),
        .s_axis_tlast  (sel_last),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    assign grant = grant_q;
    assign busy  = locked;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: packet-level round-robin model plus directed cases.
module tb_axis_rr_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          gap;   // cycles of tvalid low before this beat is offered
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata  [3];
    logic [3:0]  s_tkeep  [3];
    logic        s_tvalid [3];
    logic        s_tready [3];
    logic        s_tlast  [3];
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [1:0]  grant;
    logic        busy;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    sb_en    = 1'b0;
    beat_t in_q  [3][$];
    beat_t exp_q [$];
    int    glog  [$];
    int    mlog  [$];

    always #5 clk = ~clk;

    axis_rr_arbiter #(
        .DATA_WIDTH (32),
        .KEEP_WIDTH (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata_0  (s_tdata[0]),
        .s_axis_tkeep_0  (s_tkeep[0]),
        .s_axis_tvalid_0 (s_tvalid[0]),
        .s_axis_tready_0 (s_tready[0]),
        .s_axis_tlast_0  (s_tlast[0]),
        .s_axis_tdata_1  (s_tdata[1]),
        .s_axis_tkeep_1  (s_tkeep[1]),
        .s_axis_tvalid_1 (s_tvalid[1]),
        .s_axis_tready_1 (s_tready[1]),
        .s_axis_tlast_1  (s_tlast[1]),
        .s_axis_tdata_2  (s_tdata[2]),
        .s_axis_tkeep_2  (s_tkeep[2]),
        .s_axis_tvalid_2 (s_tvalid[2]),
        .s_axis_tready_2 (s_tready[2]),
        .s_axis_tlast_2  (s_tlast[2]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .m_axis_tlast    (m_tlast),
        .grant           (grant),
        .busy            (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 3; p++) begin
            s_tvalid[p] = 1'b0;
            s_tdata[p]  = '0;
            s_tkeep[p]  = '0;
            s_tlast[p]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        idle_inputs();
        m_tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int p = 0; p < 3; p++) in_q[p].delete();
        sb_en = 1'b1;
    endtask

    task automatic add_packet(input int p, input int len, input logic [31:0] base,
                              input logic [3:0] keep, input int first_gap,
                              input int gap_at, input int gap_len);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = base + 32'(b);
            x.keep = keep;
            x.last = (b == len - 1);
            x.gap  = (b == 0) ? first_gap : ((b == gap_at) ? gap_len : 0);
            in_q[p].push_back(x);
        end
    endtask

    task automatic push_port(input int p);
        foreach (in_q[p][i]) exp_q.push_back(in_q[p][i]);
    endtask

    // Packet-level reference: every port with work is requesting at each arbitration point,
    // so whole packets leave in rotation order starting after port 2.
    task automatic build_expected();
        int idx[3];
        int last_owner;
        bit found;
        last_owner = 2;
        for (int p = 0; p < 3; p++) idx[p] = 0;
        forever begin
            found = 1'b0;
            for (int k = 1; k <= 3 && !found; k++) begin
                int p;
                p = (last_owner + k) % 3;
                if (idx[p] < in_q[p].size()) begin
                    found = 1'b1;
                    last_owner = p;
                    while (1) begin
                        exp_q.push_back(in_q[p][idx[p]]);
                        idx[p]++;
                        if (in_q[p][idx[p]-1].last) break;
                    end
                end
            end
            if (!found) break;
        end
    endtask

    // Drive the per-port beat queues; rmode: 0 ready, 1 pattern 1,0,0, 2 random.
    task automatic run_traffic(input int rmode, input int budget);
        bit loaded[3];
        int gcnt[3];
        bit hs[3];
        bit mid[3];
        int cyc;
        bit empty;
        glog.delete();
        mlog.delete();
        for (int p = 0; p < 3; p++) begin
            loaded[p] = 0; gcnt[p] = 0; hs[p] = 0; mid[p] = 0;
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (hs[p]) begin
                    mid[p] = !in_q[p][0].last;
                    void'(in_q[p].pop_front());
                    loaded[p] = 0;
                end
            end
            empty = (in_q[0].size() == 0) && (in_q[1].size() == 0) &&
                    (in_q[2].size() == 0) && (exp_q.size() == 0);
            if (empty || cyc >= budget) break;
            for (int p = 0; p < 3; p++) begin
                if (in_q[p].size() > 0) begin
                    if (!loaded[p]) begin
                        gcnt[p] = in_q[p][0].gap;
                        loaded[p] = 1;
                    end
                    if (gcnt[p] > 0) begin
                        s_tvalid[p] = 1'b0;
                        gcnt[p]--;
                    end else begin
                        s_tvalid[p] = 1'b1;
                    end
                    s_tdata[p] = in_q[p][0].data;
                    s_tkeep[p] = in_q[p][0].keep;
                    s_tlast[p] = in_q[p][0].last;
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tdata[p]  = '0;
                    s_tkeep[p]  = '0;
                    s_tlast[p]  = 1'b0;
                end
            end
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc % 3 == 0);
                default: m_tready = ($urandom_range(3) != 0);
            endcase
            #1;
            glog.push_back(int'(grant));
            if (m_tvalid && m_tready) mlog.push_back(cyc);
            for (int p = 0; p < 3; p++) hs[p] = s_tvalid[p] && s_tready[p];
            for (int p = 0; p < 3; p++) begin
                if (mid[p]) begin
                    check("lock_busy", busy, 1);
                    check("lock_grant", grant, p);
                    check("lock_others_ready", {s_tready[(p+1)%3], s_tready[(p+2)%3]}, 0);
                end
            end
            cyc++;
        end
        check("traffic_drained", empty, 1);
        idle_inputs();
    endtask

    // Monitor: pops the scoreboard on every output handshake and guards stalls.
    logic        stall_prev;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    beat_t       e;
    initial begin
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!sb_en) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                check("stall_hold_valid", m_tvalid, 1);
                check("stall_hold_data", m_tdata, pd);
                check("stall_hold_keep", m_tkeep, pk);
                check("stall_hold_last", m_tlast, pl);
            end
            if (m_tvalid && !m_tready) begin
                check("stall_readys", {s_tready[2], s_tready[1], s_tready[0]}, 0);
            end
            if (m_tvalid && m_tready) begin
                check("sb_beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", m_tdata, e.data);
                    check("out_keep", m_tkeep, e.keep);
                    check("out_last", m_tlast, e.last);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            pd = m_tdata;
            pk = m_tkeep;
            pl = m_tlast;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int comp[$];
        int exp_g[8];
        int hsn;
        exp_g = '{3, 0, 3, 1, 3, 2, 3, 0};
        idle_inputs();
        m_tready = 1'b0;

        // Reset values
        do_reset();
        #1;
        check("rst_m_valid", m_tvalid, 0);
        check("rst_m_data", m_tdata, 0);
        check("rst_m_keep", m_tkeep, 0);
        check("rst_m_last", m_tlast, 0);
        check("rst_readys", {s_tready[2], s_tready[1], s_tready[0]}, 0);
        check("rst_grant", grant, 3);
        check("rst_busy", busy, 0);

        // Priority after reset: 2-beat packets, port 0 twice
        do_reset();
        add_packet(0, 2, 32'h0000_0100, 4'hF, 0, -1, 0);
        add_packet(0, 2, 32'h0000_0110, 4'hF, 0, -1, 0);
        add_packet(1, 2, 32'h0000_0200, 4'hF, 0, -1, 0);
        add_packet(2, 2, 32'h0000_0300, 4'hF, 0, -1, 0);
        build_expected();
        run_traffic(0, 200);
        comp.delete();
        foreach (glog[i]) if (comp.size() == 0 || comp[comp.size()-1] != glog[i]) comp.push_back(glog[i]);
        check("prio_grant_count", comp.size() >= 8, 1);
        for (int i = 0; i < 8 && i < comp.size(); i++) check("prio_grant_seq", comp[i], exp_g[i]);
        check("prio_first_latency", (mlog.size() > 0) ? mlog[0] : -1, 2);

        // Backpressure on port 1
        do_reset();
        add_packet(1, 4, 32'h0000_0011, 4'hF, 0, -1, 0);
        build_expected();
        run_traffic(1, 200);

        // Lock hold: port 2 pauses mid-packet while port 0 waits
        do_reset();
        add_packet(2, 5, 32'h2000_0020, 4'hF, 0, 2, 3);
        add_packet(0, 2, 32'h0000_0A00, 4'hF, 1, -1, 0);
        push_port(2);
        push_port(0);
        run_traffic(0, 200);

        // Single-beat packets on port 0
        do_reset();
        for (int k = 0; k < 6; k++) add_packet(0, 1, 32'h0000_5000 + 32'(k), 4'h1, 0, -1, 0);
        build_expected();
        run_traffic(0, 200);
        for (int i = 0; i < 12 && i < glog.size(); i++) check("single_grant", glog[i], (i % 2) ? 0 : 3);
        check("single_beat_count", mlog.size(), 6);
        for (int i = 1; i < mlog.size(); i++) check("single_spacing", mlog[i] - mlog[i-1], 2);

        // Randomized traffic against the round-robin model
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int p = 0; p < 3; p++) begin
                int npk;
                npk = $urandom_range(5, 1);
                for (int k = 0; k < npk; k++) begin
                    int len;
                    beat_t x;
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) begin
                        x.data = $urandom;
                        x.keep = 4'($urandom);
                        x.last = (b == len - 1);
                        x.gap  = (b == 0) ? 0 : $urandom_range(2);
                        in_q[p].push_back(x);
                    end
                end
            end
            build_expected();
            run_traffic(2, 2000);
        end

        // Reset in the middle of a 5-beat packet
        do_reset();
        sb_en = 1'b0;
        hsn = 0;
        for (int c = 0; c < 20 && hsn < 2; c++) begin
            @(negedge clk);
            s_tvalid[0] = 1'b1;
            s_tdata[0]  = 32'h0000_00A0 + 32'(hsn);
            s_tkeep[0]  = 4'hF;
            s_tlast[0]  = 1'b0;
            m_tready    = 1'b1;
            #1;
            if (s_tvalid[0] && s_tready[0]) hsn++;
        end
        check("midrst_beats_before", hsn, 2);
        @(negedge clk);
        s_tdata[0] = 32'h0000_00A2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_tvalid, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        check("midrst_next_m_valid", m_tvalid, 0);
        check("midrst_next_readys", {s_tready[2], s_tready[1], s_tready[0]}, 0);
        check("midrst_next_grant", grant, 3);
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            s_tvalid[p] = 1'b1;
            s_tdata[p]  = 32'h0000_0E00 + 32'(p);
            s_tkeep[p]  = 4'hF;
            s_tlast[p]  = 1'b1;
        end
        @(posedge clk);
        #1;
        check("midrst_after_grant", grant, 0);
        check("midrst_after_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
